// File: rtl/lcd12864_pkg.sv
// Shared types and constants for the 12864 (ST7920-style) panel responder:
// FSM states, instruction opcode masks and decode, ASCII constants, capture RAM geometry.
package lcd12864_pkg;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        CLEAR,
        BUSY
    } state_t;

    typedef enum logic [2:0] {
        CMD_NONE,
        CMD_SET_DDRAM,
        CMD_FUNC_SET,
        CMD_DISP_CTRL,
        CMD_ENTRY_MODE,
        CMD_HOME,
        CMD_CLEAR
    } cmd_t;

    localparam logic [7:0] OP_SET_DDRAM  = 8'h80;
    localparam logic [7:0] OP_SET_CGRAM  = 8'h40;
    localparam logic [7:0] OP_FUNC_SET   = 8'h20;
    localparam logic [7:0] OP_SHIFT      = 8'h10;
    localparam logic [7:0] OP_DISP_CTRL  = 8'h08;
    localparam logic [7:0] OP_ENTRY_MODE = 8'h04;
    localparam logic [7:0] OP_HOME       = 8'h02;
    localparam logic [7:0] OP_CLEAR      = 8'h01;

    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_DOT   = 8'h2E;

    localparam int unsigned RAM_DEPTH = 64;
    localparam int unsigned ADDR_W    = 6;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(RAM_DEPTH - 1);

    // Highest set bit selects the command; CGRAM and shift commands are not modelled.
    function automatic cmd_t decode_instr(input logic [7:0] d);
        cmd_t c;
        if      (|(d & OP_SET_DDRAM))  c = CMD_SET_DDRAM;
        else if (|(d & OP_SET_CGRAM))  c = CMD_NONE;
        else if (|(d & OP_FUNC_SET))   c = CMD_FUNC_SET;
        else if (|(d & OP_SHIFT))      c = CMD_NONE;
        else if (|(d & OP_DISP_CTRL))  c = CMD_DISP_CTRL;
        else if (|(d & OP_ENTRY_MODE)) c = CMD_ENTRY_MODE;
        else if (|(d & OP_HOME))       c = CMD_HOME;
        else if (|(d & OP_CLEAR))      c = CMD_CLEAR;
        else                           c = CMD_NONE;
        return c;
    endfunction

endpackage

// File: rtl/lcd_bus_sync.sv
// Two-stage synchronizer for the asynchronous LCD bus, with en edge detection
// and capture of rs/rw/dat on the synchronized rising edge of en.
module lcd_bus_sync (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       rs,
    input  logic       rw,
    input  logic [7:0] dat_in,
    output logic       en_sync,
    output logic       rs_sync,
    output logic       rw_sync,
    output logic       en_rise,
    output logic       en_fall,
    output logic       rs_lat,
    output logic       rw_lat,
    output logic [7:0] dat_lat
);

    logic [2:0] en_s;
    logic [1:0] rs_s;
    logic [1:0] rw_s;
    logic [7:0] dat_s1;
    logic [7:0] dat_s2;

    always_ff @(posedge clk) begin
        if (rst) begin
            en_s    <= '0;
            rs_s    <= '0;
            rw_s    <= '0;
            dat_s1  <= '0;
            dat_s2  <= '0;
            rs_lat  <= 1'b0;
            rw_lat  <= 1'b0;
            dat_lat <= '0;
        end else begin
            en_s   <= {en_s[1:0], en};
            rs_s   <= {rs_s[0], rs};
            rw_s   <= {rw_s[0], rw};
            dat_s1 <= dat_in;
            dat_s2 <= dat_s1;
            if (en_rise) begin
                rs_lat  <= rs_s[1];
                rw_lat  <= rw_s[1];
                dat_lat <= dat_s2;
            end
        end
    end

    assign en_sync = en_s[1];
    assign rs_sync = rs_s[1];
    assign rw_sync = rw_s[1];
    assign en_rise = en_s[1] & ~en_s[2];
    assign en_fall = ~en_s[1] & en_s[2];

endmodule

// File: rtl/lcd12864_responder.sv
// Panel-side responder for the 12864 parallel LCD bus: instruction decode, address counter,
// capture RAM writes and status reads. Busy emulation is enabled by LCD12864_BUSY_EMU_EN.
module lcd12864_responder
    import lcd12864_pkg::*;
#(
    parameter int unsigned BUSY_CYCLES = 2000,
    parameter logic [7:0]  CLEAR_FILL  = ASCII_SPACE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rs,
    input  logic              rw,
    input  logic              en,
    input  logic [7:0]        dat_in,
    output logic [7:0]        dat_out,
    output logic              dat_oe,
    output logic              cap_we,
    output logic [ADDR_W-1:0] cap_addr,
    output logic [7:0]        cap_data,
    output logic              display_on,
    output logic              busy
);

    state_t            state, state_next;
    cmd_t              cmd;
    logic              en_sync, rs_sync, rw_sync, en_rise, en_fall;
    logic              rs_lat, rw_lat;
    logic [7:0]        dat_lat;
    logic [ADDR_W-1:0] ac;
    logic [ADDR_W-1:0] clr_cnt;
    logic              inc;
    logic              ext;
    logic              accept;

    lcd_bus_sync u_sync (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .rs      (rs),
        .rw      (rw),
        .dat_in  (dat_in),
        .en_sync (en_sync),
        .rs_sync (rs_sync),
        .rw_sync (rw_sync),
        .en_rise (en_rise),
        .en_fall (en_fall),
        .rs_lat  (rs_lat),
        .rw_lat  (rw_lat),
        .dat_lat (dat_lat)
    );

    assign cmd = decode_instr(dat_lat);

    // Ignored instructions never reach EXEC, so they cannot raise busy.
    assign accept = en_fall && !rw_lat &&
                    (rs_lat || (cmd != CMD_NONE && (!ext || cmd == CMD_FUNC_SET)));

`ifdef LCD12864_BUSY_EMU_EN
    localparam state_t POST_STATE = BUSY;
    logic [31:0] busy_cnt;

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_cnt <= '0;
        end else if (state != BUSY && state_next == BUSY) begin
            busy_cnt <= BUSY_CYCLES - 1;
        end else if (state == BUSY && busy_cnt != '0) begin
            busy_cnt <= busy_cnt - 1;
        end
    end
`else
    localparam state_t POST_STATE = IDLE;

    assign busy = (state == CLEAR);
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (accept) state_next = EXEC;
            EXEC:  state_next = (!rs_lat && cmd == CMD_CLEAR) ? CLEAR : POST_STATE;
            CLEAR: if (clr_cnt == LAST_ADDR) state_next = POST_STATE;
`ifdef LCD12864_BUSY_EMU_EN
            BUSY:  if (busy_cnt == '0) state_next = IDLE;
`endif
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ac         <= '0;
            inc        <= 1'b1;
            ext        <= 1'b0;
            display_on <= 1'b0;
            clr_cnt    <= '0;
            cap_we     <= 1'b0;
            cap_addr   <= '0;
            cap_data   <= '0;
            dat_out    <= '0;
            dat_oe     <= 1'b0;
        end else begin
            cap_we <= 1'b0;
            case (state)
                EXEC: begin
                    if (rs_lat) begin
                        cap_we   <= 1'b1;
                        cap_addr <= ac;
                        cap_data <= dat_lat;
                        ac       <= inc ? ac + 6'd1 : ac - 6'd1;
                    end else begin
                        case (cmd)
                            CMD_SET_DDRAM:  ac         <= {dat_lat[4:0], 1'b0};
                            CMD_FUNC_SET:   ext        <= dat_lat[2];
                            CMD_DISP_CTRL:  display_on <= dat_lat[2];
                            CMD_ENTRY_MODE: inc        <= dat_lat[1];
                            CMD_HOME:       ac         <= '0;
                            CMD_CLEAR:      clr_cnt    <= '0;
                            default:        ;
                        endcase
                    end
                end
                CLEAR: begin
                    cap_we   <= 1'b1;
                    cap_addr <= clr_cnt;
                    cap_data <= CLEAR_FILL;
                    clr_cnt  <= clr_cnt + 6'd1;
                    if (clr_cnt == LAST_ADDR) begin
                        ac  <= '0;
                        inc <= 1'b1;
                    end
                end
                default: ;
            endcase

            dat_oe <= en_sync & rw_sync & ~rs_sync;
            if (en_sync && rw_sync && !rs_sync) dat_out <= {busy, 1'b0, ac};
            else                                dat_out <= 8'h00;
        end
    end

endmodule
